// File: rtl/if_fetch_unit_pkg.sv
// Shared fetch/decode definitions: state encoding, bubble word and bus widths.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package if_fetch_unit_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 32;

    // Opcode 000000 decodes as a NOP, so an all-zero word is a safe bubble.
    localparam logic [INSTR_W-1:0] NOP_WORD = '0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2,
        S_DRAIN = 2'd3
    } fetch_state_e;

    // IF/ID pipeline register contents.
    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc_out;
    } if_id_t;

endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/response bus between fetch and imem.
// Latency: variable; imem_ack is a one-cycle strobe with imem_rdata valid alongside.
// Backpressure: requester keeps imem_req and imem_addr stable until imem_ack.
interface if_fetch_unit_if;
    import if_fetch_unit_pkg::*;

    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/if_fetch_unit_if_id_reg.sv
// IF/ID pipeline register holding the instruction and PC+step for decode.
// Latency: one cycle from load to output.
// Backpressure: flush beats hold beats load; with none asserted the contents persist.
module if_id_reg
    import if_fetch_unit_pkg::*;
#(
    parameter logic [INSTR_W-1:0] NOP = if_fetch_unit_pkg::NOP_WORD
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   load,
    input  logic   flush,
    input  logic   hold,
    input  if_id_t d,
    output if_id_t q
);

    if_id_t if_id_d;
    if_id_t if_id_q;

    // Select the next register contents from the control priority.
    always_comb begin
        if_id_d = if_id_q;
        if (flush) begin
            if_id_d.instr  = NOP;
            if_id_d.pc_out = '0;
        end else if (hold) begin
            if_id_d = if_id_q;
        end else if (load) begin
            if_id_d = d;
        end
    end

    // Register with async clear to a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_id_q.instr  <= NOP;
            if_id_q.pc_out <= '0;
        end else begin
            if_id_q <= if_id_d;
        end
    end

    assign q = if_id_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch: owns the PC, requests words from imem and feeds decode via IF/ID.
// Latency: an acked word reaches IF/ID on the next clock; one instruction per cycle at zero wait.
// Backpressure: freez holds PC and IF/ID (acked word parked in hold_buf); bubbles while imem is slow.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [ADDR_W-1:0]  RESET_PC = 32'h0000_0000,
    parameter int unsigned        PC_STEP  = 4,
    parameter logic [INSTR_W-1:0] NOP_WORD = if_fetch_unit_pkg::NOP_WORD
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                freez,
    input  logic                branch_taken,
    input  logic [ADDR_W-1:0]   branch_addr,
    if_fetch_unit_if.master     imem,
    output logic [INSTR_W-1:0]  instruction,
    output logic [ADDR_W-1:0]   PCOut,
    output logic                fetch_pending
);

    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

    fetch_state_e       state_d, state_q;
    logic [ADDR_W-1:0]  pc_d, pc_q;
    logic [INSTR_W-1:0] hold_buf_d, hold_buf_q;
    // Address of the request still in flight when a redirect moved pc away.
    logic [ADDR_W-1:0]  drain_addr_d, drain_addr_q;

    logic [ADDR_W-1:0]  pc_next;
    logic               ifid_load, ifid_flush, ifid_hold;
    if_id_t             ifid_in, ifid_out;

    assign pc_next = pc_q + STEP;

    // Next-state, PC and IF/ID control; branch beats freez beats normal flow.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        hold_buf_d   = hold_buf_q;
        drain_addr_d = drain_addr_q;
        ifid_load    = 1'b0;
        ifid_flush   = 1'b0;
        ifid_hold    = freez & ~branch_taken;
        ifid_in      = '{instr: imem.imem_rdata, pc_out: pc_next};

        if (branch_taken) begin
            ifid_flush = 1'b1;
            pc_d       = branch_addr;
            hold_buf_d = '0;
        end

        unique case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                if (branch_taken) begin
                    // Without an ack the old request must still complete and be dropped.
                    state_d      = imem.imem_ack ? S_FETCH : S_DRAIN;
                    drain_addr_d = pc_q;
                end else if (imem.imem_ack) begin
                    if (freez) begin
                        hold_buf_d = imem.imem_rdata;
                        state_d    = S_HOLD;
                    end else begin
                        ifid_load = 1'b1;
                        pc_d      = pc_next;
                    end
                end else if (!freez) begin
                    ifid_flush = 1'b1;
                end
            end
            S_HOLD: begin
                if (branch_taken) begin
                    state_d = S_FETCH;
                end else if (!freez) begin
                    ifid_load     = 1'b1;
                    ifid_in.instr = hold_buf_q;
                    pc_d          = pc_next;
                    state_d       = S_FETCH;
                end
            end
            S_DRAIN: begin
                if (imem.imem_ack) begin
                    state_d = S_FETCH;
                end
                if (!branch_taken && !freez) begin
                    ifid_flush = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Fetch state, PC, hold buffer and drain address registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            hold_buf_q   <= '0;
            drain_addr_q <= RESET_PC;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            hold_buf_q   <= hold_buf_d;
            drain_addr_q <= drain_addr_d;
        end
    end

    if_id_reg #(
        .NOP (NOP_WORD)
    ) u_if_id_reg (
        .clk   (clk),
        .rst_n (rst),
        .load  (ifid_load),
        .flush (ifid_flush),
        .hold  (ifid_hold),
        .d     (ifid_in),
        .q     (ifid_out)
    );

    assign imem.imem_req  = (state_q == S_FETCH) || (state_q == S_DRAIN);
    assign imem.imem_addr = (state_q == S_DRAIN) ? drain_addr_q : pc_q;
    assign fetch_pending  = imem.imem_req & ~imem.imem_ack;
    assign instruction    = ifid_out.instr;
    assign PCOut          = ifid_out.pc_out;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit with a programmable-latency memory model.
// Latency: memory acks after mem_lat request cycles; word = {16'hC0DE, addr[15:0]}.
// Backpressure: freez and branch driven directly as directed steps.
module tb_if_fetch_unit;

    logic        clk;
    logic        rst;
    logic        freez;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic [31:0] instruction;
    logic [31:0] PCOut;
    logic        fetch_pending;

    int checks = 0;
    int errors = 0;
    int mem_lat = 1;
    int wait_cnt = 0;

    if_fetch_unit_if imem_bus();

    if_fetch_unit dut (
        .clk           (clk),
        .rst           (rst),
        .freez         (freez),
        .branch_taken  (branch_taken),
        .branch_addr   (branch_addr),
        .imem          (imem_bus),
        .instruction   (instruction),
        .PCOut         (PCOut),
        .fetch_pending (fetch_pending)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory model: decides shortly after each edge whether to ack the current request.
    always @(posedge clk) begin
        #1;
        if (!rst || !imem_bus.imem_req) begin
            imem_bus.imem_ack   = 1'b0;
            imem_bus.imem_rdata = 32'h0;
            wait_cnt            = 0;
        end else if (wait_cnt + 1 >= mem_lat) begin
            imem_bus.imem_ack   = 1'b1;
            imem_bus.imem_rdata = {16'hC0DE, imem_bus.imem_addr[15:0]};
            wait_cnt            = 0;
        end else begin
            imem_bus.imem_ack   = 1'b0;
            wait_cnt            = wait_cnt + 1;
        end
    end

    task automatic step();
        @(posedge clk);
        #3;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_ifid(input string tag, input logic [31:0] exp_instr, input logic [31:0] exp_pc);
        chk({tag, "_instr"}, instruction, exp_instr);
        chk({tag, "_pcout"}, PCOut, exp_pc);
    endtask

    initial begin
        rst          = 1'b0;
        freez        = 1'b0;
        branch_taken = 1'b0;
        branch_addr  = 32'h0;
        mem_lat      = 1;

        // Reset values
        step();
        chk_ifid("rst", 32'h0, 32'h0);
        chk("rst_req", 32'(imem_bus.imem_req), 32'h0);
        chk("rst_addr", imem_bus.imem_addr, 32'h0);
        chk("rst_pend", 32'(fetch_pending), 32'h0);
        rst = 1'b1;

        // Idle cycle done, first request at RESET_PC acked immediately
        step();
        chk("f0_req", 32'(imem_bus.imem_req), 32'h1);
        chk("f0_addr", imem_bus.imem_addr, 32'h0);
        chk_ifid("f0", 32'h0, 32'h0);
        chk("f0_pend", 32'(fetch_pending), 32'h0);
        step();
        chk_ifid("zw0", 32'hC0DE_0000, 32'h4);
        chk("zw0_addr", imem_bus.imem_addr, 32'h4);
        chk("zw0_req", 32'(imem_bus.imem_req), 32'h1);
        step();
        chk_ifid("zw1", 32'hC0DE_0004, 32'h8);
        step();
        chk_ifid("zw2", 32'hC0DE_0008, 32'hC);
        chk("zw2_req", 32'(imem_bus.imem_req), 32'h1);

        // Three-cycle memory: address stable, two bubbles, then data
        mem_lat = 3;
        step();
        chk_ifid("l3_a", 32'hC0DE_000C, 32'h10);
        chk("l3_a_addr", imem_bus.imem_addr, 32'h10);
        chk("l3_a_pend", 32'(fetch_pending), 32'h1);
        step();
        chk_ifid("l3_b", 32'h0, 32'h0);
        chk("l3_b_addr", imem_bus.imem_addr, 32'h10);
        chk("l3_b_pend", 32'(fetch_pending), 32'h1);
        step();
        chk_ifid("l3_c", 32'h0, 32'h0);
        chk("l3_c_addr", imem_bus.imem_addr, 32'h10);
        chk("l3_c_pend", 32'(fetch_pending), 32'h0);
        mem_lat = 1;
        step();
        chk_ifid("l3_d", 32'hC0DE_0010, 32'h14);
        chk("l3_d_addr", imem_bus.imem_addr, 32'h14);

        // Freeze on an acked cycle for four cycles
        freez = 1'b1;
        step();
        chk("fz0_req", 32'(imem_bus.imem_req), 32'h0);
        chk_ifid("fz0", 32'hC0DE_0010, 32'h14);
        chk("fz0_pend", 32'(fetch_pending), 32'h0);
        step();
        step();
        step();
        chk("fz3_req", 32'(imem_bus.imem_req), 32'h0);
        chk_ifid("fz3", 32'hC0DE_0010, 32'h14);
        chk("fz3_addr", imem_bus.imem_addr, 32'h14);
        freez = 1'b0;
        step();
        chk_ifid("fzr", 32'hC0DE_0014, 32'h18);
        chk("fzr_req", 32'(imem_bus.imem_req), 32'h1);
        chk("fzr_addr", imem_bus.imem_addr, 32'h18);

        // Redirect during an outstanding two-cycle fetch
        mem_lat = 2;
        step();
        chk_ifid("fzn", 32'hC0DE_0018, 32'h1C);
        chk("br_pre_addr", imem_bus.imem_addr, 32'h1C);
        chk("br_pre_pend", 32'(fetch_pending), 32'h1);
        branch_taken = 1'b1;
        branch_addr  = 32'h100;
        step();
        branch_taken = 1'b0;
        chk_ifid("br_flush", 32'h0, 32'h0);
        chk("br_drain_addr", imem_bus.imem_addr, 32'h1C);
        chk("br_drain_req", 32'(imem_bus.imem_req), 32'h1);
        step();
        chk_ifid("br_drop", 32'h0, 32'h0);
        chk("br_new_addr", imem_bus.imem_addr, 32'h100);
        chk("br_new_pend", 32'(fetch_pending), 32'h1);
        step();
        chk_ifid("br_wait", 32'h0, 32'h0);
        chk("br_wait_addr", imem_bus.imem_addr, 32'h100);
        mem_lat = 1;
        step();
        chk_ifid("br_tgt", 32'hC0DE_0100, 32'h104);
        chk("br_tgt_addr", imem_bus.imem_addr, 32'h104);

        // Branch + freez + ack in the same cycle
        branch_taken = 1'b1;
        branch_addr  = 32'h200;
        freez        = 1'b1;
        step();
        branch_taken = 1'b0;
        freez        = 1'b0;
        chk_ifid("bf_flush", 32'h0, 32'h0);
        chk("bf_addr", imem_bus.imem_addr, 32'h200);
        chk("bf_req", 32'(imem_bus.imem_req), 32'h1);
        mem_lat = 4;
        step();
        chk_ifid("bf_tgt", 32'hC0DE_0200, 32'h204);
        chk("bf_pend", 32'(fetch_pending), 32'h1);

        // Reset asserted in the middle of a drain
        branch_taken = 1'b1;
        branch_addr  = 32'h300;
        step();
        branch_taken = 1'b0;
        chk("dr_addr", imem_bus.imem_addr, 32'h204);
        chk("dr_req", 32'(imem_bus.imem_req), 32'h1);
        #2;
        rst = 1'b0;
        #1;
        chk("ar_req", 32'(imem_bus.imem_req), 32'h0);
        chk("ar_addr", imem_bus.imem_addr, 32'h0);
        chk_ifid("ar", 32'h0, 32'h0);
        chk("ar_pend", 32'(fetch_pending), 32'h0);
        step();
        rst     = 1'b1;
        mem_lat = 1;
        step();
        chk("rs_req", 32'(imem_bus.imem_req), 32'h1);
        chk("rs_addr", imem_bus.imem_addr, 32'h0);
        step();
        chk_ifid("rs_first", 32'hC0DE_0000, 32'h4);

        // PC wrap at the top of the address space
        branch_taken = 1'b1;
        branch_addr  = 32'hFFFF_FFFC;
        step();
        branch_taken = 1'b0;
        chk("wr_addr", imem_bus.imem_addr, 32'hFFFF_FFFC);
        chk_ifid("wr_flush", 32'h0, 32'h0);
        step();
        chk_ifid("wr_data", 32'hC0DE_FFFC, 32'h0);
        chk("wr_next_addr", imem_bus.imem_addr, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
